// File: rtl/stack_arith_unit_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// stack_arith_unit_pkg : command codes and FSM states shared by the stack unit
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
package stack_arith_unit_pkg;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_PUSH = 3'd1;
  localparam logic [2:0] OP_POP  = 3'd2;
  localparam logic [2:0] OP_ADD  = 3'd3;
  localparam logic [2:0] OP_SUB  = 3'd4;
  localparam logic [2:0] OP_MUL  = 3'd5;
  localparam logic [2:0] OP_DIV  = 3'd6;

  typedef enum logic [1:0] {
    STATE_IDLE    = 2'd0,
    STATE_DIV_RUN = 2'd1,
    STATE_DIV_WB  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/stack_divider.sv
`default_nettype none
// ----------------------------------------------------------------------------
// stack_divider : WIDTH-cycle restoring divider on magnitudes with sign fixup
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
module stack_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic             running;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic             neg;
  logic             ovf;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  always_comb begin
    mag_a   = (signed_mode && dividend[WIDTH-1]) ? -dividend : dividend;
    mag_b   = (signed_mode && divisor[WIDTH-1])  ? -divisor  : divisor;
    shifted = {rem[WIDTH-1:0], quo[WIDTH-1]};
    trial   = shifted - {1'b0, dvs};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      running <= 1'b0;
      cnt     <= '0;
      rem     <= '0;
      quo     <= '0;
      dvs     <= '0;
      neg     <= 1'b0;
      ovf     <= 1'b0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
      rem     <= '0;
      quo     <= mag_a;
      dvs     <= mag_b;
      neg     <= signed_mode && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
      ovf     <= signed_mode && (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (&divisor);
    end else if (running) begin
      // A negative trial remainder means this quotient bit is 0: restore.
      if (trial[WIDTH]) begin
        rem <= shifted;
        quo <= {quo[WIDTH-2:0], 1'b0};
      end else begin
        rem <= trial;
        quo <= {quo[WIDTH-2:0], 1'b1};
      end
      cnt <= cnt + 1'b1;
      if (cnt == LAST) running <= 1'b0;
    end
  end

  // MIN/-1 magnitude quotient is 2^(WIDTH-1), which reads back as MIN unchanged.
  assign busy     = running;
  assign done     = running && (cnt == LAST);
  assign quotient = neg ? -quo : quo;
  assign overflow = ovf;

endmodule
`default_nettype wire

// File: rtl/stack_arith_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// stack_arith_unit : operand stack with add/sub/mul and multi-cycle divide
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
module stack_arith_unit
  import stack_arith_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [2:0]               cmd_op,
  input  logic [WIDTH-1:0]         cmd_data,
  input  logic                     signed_mode,
  output logic [WIDTH-1:0]         tos,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     done,
  output logic                     carry_out,
  output logic                     overflow,
  output logic                     div_zero,
  output logic                     stk_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0]   mem [DEPTH];
  state_t             state;
  logic               pend_stk, pend_zero;
  logic [CNT_W-1:0]   count_m1, count_m2;
  logic [WIDTH-1:0]   a, b;
  logic               accept, have_two, binop;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   diff;
  logic [2*WIDTH-1:0] prod_u;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c, alu_v;
  logic               wr_en;
  logic [PTR_W-1:0]   wr_addr;
  logic [WIDTH-1:0]   wr_data;
  logic               div_start, div_busy, div_done, div_ovf;
  logic [WIDTH-1:0]   div_q;

  assign count_m1  = count - CNT_W'(1);
  assign count_m2  = count - CNT_W'(2);
  assign a         = mem[count_m2[PTR_W-1:0]];
  assign b         = mem[count_m1[PTR_W-1:0]];
  assign tos       = (count == '0) ? '0 : b;
  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(DEPTH));
  assign cmd_ready = (state == STATE_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign have_two  = (count >= CNT_W'(2));
  assign binop     = (cmd_op == OP_ADD) || (cmd_op == OP_SUB) || (cmd_op == OP_MUL);
  assign div_start = accept && (cmd_op == OP_DIV) && have_two && (b != '0);

  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    diff   = a - b;
    prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
    alu_res = sum[WIDTH-1:0];
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (cmd_op)
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = signed_mode && (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_c   = (a < b);
        alu_v   = signed_mode && (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_MUL: begin
        alu_res = signed_mode ? prod_s[WIDTH-1:0] : prod_u[WIDTH-1:0];
        alu_c   = !signed_mode && (|prod_u[2*WIDTH-1:WIDTH]);
        // Signed product fits only if the upper half plus sign bit are all equal.
        alu_v   = signed_mode && (|prod_s[2*WIDTH-1:WIDTH-1]) && !(&prod_s[2*WIDTH-1:WIDTH-1]);
      end
      default: ;
    endcase
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = count_m2[PTR_W-1:0];
    wr_data = alu_res;
    if (state == STATE_IDLE && accept) begin
      if (cmd_op == OP_PUSH && !full) begin
        wr_en   = 1'b1;
        wr_addr = count[PTR_W-1:0];
        wr_data = cmd_data;
      end else if (binop && have_two) begin
        wr_en = 1'b1;
      end
    end else if (state == STATE_DIV_WB && !pend_stk && !pend_zero) begin
      wr_en   = 1'b1;
      wr_data = div_q;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= STATE_IDLE;
      count     <= '0;
      done      <= 1'b0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      div_zero  <= 1'b0;
      stk_err   <= 1'b0;
      pend_stk  <= 1'b0;
      pend_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        STATE_IDLE: begin
          if (accept) begin
            if (cmd_op == OP_DIV) begin
              pend_stk  <= !have_two;
              pend_zero <= have_two && (b == '0);
              state     <= div_start ? STATE_DIV_RUN : STATE_DIV_WB;
            end else begin
              done      <= 1'b1;
              carry_out <= 1'b0;
              overflow  <= 1'b0;
              div_zero  <= 1'b0;
              stk_err   <= 1'b0;
              if (cmd_op == OP_PUSH) begin
                if (full) stk_err <= 1'b1;
                else      count   <= count + CNT_W'(1);
              end else if (cmd_op == OP_POP) begin
                if (empty) stk_err <= 1'b1;
                else       count   <= count_m1;
              end else if (binop) begin
                if (!have_two) begin
                  stk_err <= 1'b1;
                end else begin
                  count     <= count_m1;
                  carry_out <= alu_c;
                  overflow  <= alu_v;
                end
              end
            end
          end
        end
        STATE_DIV_RUN: begin
          if (div_done || !div_busy) state <= STATE_DIV_WB;
        end
        STATE_DIV_WB: begin
          state     <= STATE_IDLE;
          done      <= 1'b1;
          carry_out <= 1'b0;
          overflow  <= !pend_stk && !pend_zero && div_ovf;
          div_zero  <= pend_zero;
          stk_err   <= pend_stk;
          if (!pend_stk && !pend_zero) count <= count_m1;
        end
        default: state <= STATE_IDLE;
      endcase
    end
  end

  stack_divider #(.WIDTH(WIDTH)) u_div (
    .clk         (clk),
    .reset       (reset),
    .start       (div_start),
    .signed_mode (signed_mode),
    .dividend    (a),
    .divisor     (b),
    .busy        (div_busy),
    .done        (div_done),
    .quotient    (div_q),
    .overflow    (div_ovf)
  );

endmodule
`default_nettype wire

// File: tb/tb_stack_arith_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_stack_arith_unit : directed self-checking bench for stack_arith_unit
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
module tb_stack_arith_unit;
  import stack_arith_unit_pkg::*;

  localparam int W = 8;
  localparam int D = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [2:0]   cmd_op = OP_NOP;
  logic [W-1:0] cmd_data = '0;
  logic         signed_mode = 1'b0;
  logic [W-1:0] tos;
  logic [4:0]   count;
  logic         empty, full, done, carry_out, overflow, div_zero, stk_err;

  int checks = 0;
  int errors = 0;
  int cyc;
  bit rdy_bad;
  bit saw_done;

  stack_arith_unit #(.WIDTH(W), .DEPTH(D)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_data    (cmd_data),
    .signed_mode (signed_mode),
    .tos         (tos),
    .count       (count),
    .empty       (empty),
    .full        (full),
    .done        (done),
    .carry_out   (carry_out),
    .overflow    (overflow),
    .div_zero    (div_zero),
    .stk_err     (stk_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one command at the falling edge; returns 1 time unit after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] data, input logic sm);
    int n;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) check("issue_ready_timeout", 32'(cmd_ready), 32'd1);
    cmd_valid   = 1'b1;
    cmd_op      = op;
    cmd_data    = data;
    signed_mode = sm;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
  endtask

  // Counts cycles after acceptance until done; flags any cycle with cmd_ready high before done.
  task automatic wait_done(output int n, output bit bad);
    n   = 0;
    bad = 1'b0;
    while (!done && n < 30) begin
      if (cmd_ready) bad = 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    if (!done) check("wait_done_timeout", 32'(done), 32'd1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_tos", 32'(tos), 32'd0);
    check("rst_flags", 32'({carry_out, overflow, div_zero, stk_err}), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Unsigned ADD
    issue(OP_PUSH, 8'd7, 1'b0);
    issue(OP_PUSH, 8'd2, 1'b0);
    issue(OP_ADD, 8'd0, 1'b0);
    check("add_tos", 32'(tos), 32'd9);
    check("add_count", 32'(count), 32'd1);
    check("add_carry", 32'(carry_out), 32'd0);
    check("add_done", 32'(done), 32'd1);
    issue(OP_POP, 8'd0, 1'b0);
    check("pop_empty", 32'(empty), 32'd1);

    issue(OP_PUSH, 8'hF0, 1'b0);
    issue(OP_PUSH, 8'h20, 1'b0);
    issue(OP_ADD, 8'd0, 1'b0);
    check("addc_tos", 32'(tos), 32'h10);
    check("addc_carry", 32'(carry_out), 32'd1);
    issue(OP_POP, 8'd0, 1'b0);

    issue(OP_PUSH, 8'h7F, 1'b1);
    issue(OP_PUSH, 8'h01, 1'b1);
    issue(OP_ADD, 8'd0, 1'b1);
    check("adds_tos", 32'(tos), 32'h80);
    check("adds_ovf", 32'(overflow), 32'd1);
    issue(OP_POP, 8'd0, 1'b0);

    // Signed SUB 4-6
    issue(OP_PUSH, 8'd4, 1'b1);
    issue(OP_PUSH, 8'd6, 1'b1);
    issue(OP_SUB, 8'd0, 1'b1);
    check("sub_tos", 32'(tos), 32'hFE);
    check("sub_ovf", 32'(overflow), 32'd0);
    check("sub_borrow", 32'(carry_out), 32'd1);
    issue(OP_POP, 8'd0, 1'b0);

    // Signed MUL
    issue(OP_PUSH, 8'd3, 1'b1);
    issue(OP_PUSH, 8'hFA, 1'b1);
    issue(OP_MUL, 8'd0, 1'b1);
    check("muls_tos", 32'(tos), 32'hEE);
    check("muls_ovf", 32'(overflow), 32'd0);
    issue(OP_POP, 8'd0, 1'b0);
    issue(OP_PUSH, 8'd64, 1'b1);
    issue(OP_PUSH, 8'd4, 1'b1);
    issue(OP_MUL, 8'd0, 1'b1);
    check("mulovf_tos", 32'(tos), 32'h00);
    check("mulovf_ovf", 32'(overflow), 32'd1);
    issue(OP_POP, 8'd0, 1'b0);
    issue(OP_PUSH, 8'd64, 1'b0);
    issue(OP_PUSH, 8'd4, 1'b0);
    issue(OP_MUL, 8'd0, 1'b0);
    check("mulu_carry", 32'(carry_out), 32'd1);
    issue(OP_POP, 8'd0, 1'b0);

    // Unsigned DIV 54/27: result WIDTH+1 cycles after acceptance
    issue(OP_PUSH, 8'd54, 1'b0);
    issue(OP_PUSH, 8'd27, 1'b0);
    issue(OP_DIV, 8'd0, 1'b0);
    wait_done(cyc, rdy_bad);
    check("div_latency", 32'(cyc), 32'd9);
    check("div_ready_low", 32'(rdy_bad), 32'd0);
    check("div_tos", 32'(tos), 32'd2);
    check("div_count", 32'(count), 32'd1);
    check("div_ready_back", 32'(cmd_ready), 32'd1);
    issue(OP_POP, 8'd0, 1'b0);

    // Signed MIN / -1
    issue(OP_PUSH, 8'h80, 1'b1);
    issue(OP_PUSH, 8'hFF, 1'b1);
    issue(OP_DIV, 8'd0, 1'b1);
    wait_done(cyc, rdy_bad);
    check("divmin_tos", 32'(tos), 32'h80);
    check("divmin_ovf", 32'(overflow), 32'd1);
    issue(OP_POP, 8'd0, 1'b0);

    // Signed -7 / 2 truncates toward zero
    issue(OP_PUSH, 8'hF9, 1'b1);
    issue(OP_PUSH, 8'h02, 1'b1);
    issue(OP_DIV, 8'd0, 1'b1);
    wait_done(cyc, rdy_bad);
    check("divneg_tos", 32'(tos), 32'hFD);
    check("divneg_ovf", 32'(overflow), 32'd0);
    issue(OP_POP, 8'd0, 1'b0);

    // Divide by zero leaves the stack untouched
    issue(OP_PUSH, 8'd5, 1'b0);
    issue(OP_PUSH, 8'd0, 1'b0);
    issue(OP_DIV, 8'd0, 1'b0);
    wait_done(cyc, rdy_bad);
    check("div0_flag", 32'(div_zero), 32'd1);
    check("div0_stkerr", 32'(stk_err), 32'd0);
    check("div0_count", 32'(count), 32'd2);
    check("div0_tos", 32'(tos), 32'd0);
    issue(OP_POP, 8'd0, 1'b0);
    issue(OP_POP, 8'd0, 1'b0);

    // Full / overflow push / underflow pop
    for (int i = 0; i < D; i++) issue(OP_PUSH, 8'(i), 1'b0);
    check("fill_full", 32'(full), 32'd1);
    check("fill_count", 32'(count), 32'd16);
    issue(OP_PUSH, 8'hAA, 1'b0);
    check("push_full_err", 32'(stk_err), 32'd1);
    check("push_full_count", 32'(count), 32'd16);
    check("push_full_tos", 32'(tos), 32'h0F);
    for (int i = 0; i < D; i++) issue(OP_POP, 8'd0, 1'b0);
    check("drain_empty", 32'(empty), 32'd1);
    issue(OP_POP, 8'd0, 1'b0);
    check("pop_empty_err", 32'(stk_err), 32'd1);
    check("pop_empty_count", 32'(count), 32'd0);

    // Binary op with one entry
    issue(OP_PUSH, 8'd9, 1'b0);
    issue(OP_ADD, 8'd0, 1'b0);
    check("add1_err", 32'(stk_err), 32'd1);
    check("add1_tos", 32'(tos), 32'd9);
    check("add1_count", 32'(count), 32'd1);
    issue(OP_NOP, 8'd0, 1'b0);
    check("nop_done", 32'(done), 32'd1);
    check("nop_flags", 32'({carry_out, overflow, div_zero, stk_err}), 32'd0);
    issue(OP_POP, 8'd0, 1'b0);

    // Reset in the middle of a divide
    issue(OP_PUSH, 8'd54, 1'b0);
    issue(OP_PUSH, 8'd27, 1'b0);
    issue(OP_DIV, 8'd0, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_count", 32'(count), 32'd0);
    check("abort_empty", 32'(empty), 32'd1);
    check("abort_ready", 32'(cmd_ready), 32'd1);
    check("abort_tos", 32'(tos), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    saw_done = 1'b0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (done) saw_done = 1'b1;
    end
    check("abort_no_done", 32'(saw_done), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
